alu_command_initiator: RTL and testbench
========================================

Name: alu_command_initiator

Overview:
Sequential front-end that drives the 32-bit combinational ALU from a valid/ready command stream. It accepts one command at a time and presents the operands and opcode to the ALU. It holds them for a programmable settle window, then samples Result/Carry and returns them on a valid/ready response port. It is the initiator side of the ALU operand/result interface. It adds divide-by-zero screening, result chaining and an operation counter.

Parameters:
SETTLE_CYCLES, 2, cycles ALU inputs are held with enable high before sampling; legal 1..15
COUNT_WIDTH, 16, width of the completed-operation counter

Ports:
Clk_In  input  1  clock, rising edge
Reset_In  input  1  asynchronous, active-high reset
Cmd_Valid_In  input  1  command present
Cmd_Ready_Out  output  1  block can accept a command
Cmd_Op_In  input  4  ALU opcode; 0x0..0xF, same encoding as the ALU
Cmd_Chain_In  input  1  use last captured result as operand A; Cmd_A_In ignored
Cmd_A_In  input  32  operand A
Cmd_B_In  input  32  operand B
ALU_Enable_Out  output  1  ALU enable
ALU_Operation_Select_Out  output  4  ALU opcode
ALU_Data_A_Out  output  32  ALU operand A
ALU_Data_B_Out  output  32  ALU operand B
ALU_Result_In  input  32  ALU result
ALU_Carry_In  input  1  ALU carry
Rsp_Valid_Out  output  1  response present
Rsp_Ready_In  input  1  consumer accepts response
Rsp_Result_Out  output  32  captured result
Rsp_Carry_Out  output  1  captured carry
Rsp_Error_Out  output  1  divide/modulo by zero; ALU not exercised
Op_Count_Out  output  COUNT_WIDTH  completed responses, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Reset (async assert, sync deassert use): all outputs 0, chain register 0, FSM IDLE.
- Cmd_Ready_Out is 1 exactly when the FSM is in IDLE and reset is inactive.
- Accept cycle t: Cmd_Valid_In & Cmd_Ready_Out.
- On accept, register the operands and the opcode.
- Effective A = chain register if Cmd_Chain_In, else Cmd_A_In.
- FSM states:
  - IDLE: on accept with op 0x6/0x7 and B==0, go to RESPOND. Result=0xFFFFFFFF, Carry=0, Error=1, no ALU enable pulse. On any other accept, go to DRIVE with settle counter=0.
  - DRIVE: ALU_Enable_Out=1 and ALU_* outputs driven with the registered command. On each cycle the counter increments. When counter==SETTLE_CYCLES-1, sample ALU_Result_In/ALU_Carry_In into the Rsp registers, set Error=0, load the chain register with the result, and go to RESPOND.
  - RESPOND: Rsp_Valid_Out=1, Rsp_* stable. On Rsp_Ready_In=1, increment Op_Count_Out and go to IDLE.
- ALU_Enable_Out is 1 for exactly SETTLE_CYCLES cycles (t+1..t+SETTLE_CYCLES) and 0 in every other state.
- ALU_Data_*/Op outputs hold their last values outside DRIVE; they are never forced to 0 except by reset.
- Latency: normal op Rsp_Valid_Out rises at t+1+SETTLE_CYCLES. Error op rises at t+1.
- No bypass: after a response handshake at cycle r, Cmd_Ready_Out=1 at r+1. Maximum throughput is one op per SETTLE_CYCLES+2 cycles.
- Error responses do not update the chain register. They do increment Op_Count_Out.
- Chain with no prior result uses chain register value 0.
- Commands presented while Cmd_Ready_Out=0 are ignored. Cmd_* may change freely while not ready.
- Backpressure: Rsp_Valid_Out stays 1 and Rsp_* stay unchanged for as long as Rsp_Ready_In=0.
- Reset mid-operation (any state): ALU_Enable_Out and Rsp_Valid_Out drop immediately (asynchronously). The in-flight command is discarded without a response, and the counter and chain register clear.
- Op_Count_Out at all-ones plus one completion wraps to 0.

Test Plan:
- Reset: hold Reset_In 3 cycles -> all outputs 0. Cmd_Ready_Out=1 in the first cycle after release.
- Carry: op 0x2, A=0xFFFFFFFF, B=0x00000001, SETTLE_CYCLES=2, real ALU attached:
  - ALU_Enable_Out high 2 cycles.
  - Rsp_Valid_Out at t+3 with Result=0x00000000, Carry=1, Error=0.
  - Op_Count_Out=1 after the handshake.
- Divide by zero: op 0x6, A=0x1234, B=0 -> no ALU_Enable_Out pulse; Rsp_Valid_Out at t+1 with Result=0xFFFFFFFF, Carry=0, Error=1. Then op 0x7, B=0 -> same response.
- Chaining: op 0x2, A=5, B=7 -> Result=0x0000000C. Then chained op 0x5, B=3 -> ALU_Data_A_Out=0x0000000C, Result=0x00000024. Then chained op 0x3 with B=0x24 -> Result=0x00000000.
- Backpressure:
  - Hold Rsp_Ready_In=0 for 5 cycles in RESPOND -> Rsp_* unchanged, Cmd_Ready_Out=0, and a pending command with Cmd_Valid_In=1 is not accepted.
  - Assert Rsp_Ready_In -> Cmd_Ready_Out=1 on the next cycle and the pending command is accepted then.
- Reset mid-DRIVE: assert Reset_In in the 2nd enable cycle -> ALU_Enable_Out falls immediately, no Rsp_Valid_Out ever appears for that command, and Op_Count_Out=0. A following chained op 0x0 returns Result=0x00000001.

Source files
------------

// File: rtl/alu_command_initiator.sv
// Valid/ready front-end for the 32-bit combinational ALU: captures one command,
// holds it on the ALU inputs for a settle window, then returns Result/Carry.
module alu_command_initiator #(
    parameter int SETTLE_CYCLES = 2,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   Clk_In,
    input  logic                   Reset_In,
    input  logic                   Cmd_Valid_In,
    output logic                   Cmd_Ready_Out,
    input  logic [3:0]             Cmd_Op_In,
    input  logic                   Cmd_Chain_In,
    input  logic [31:0]            Cmd_A_In,
    input  logic [31:0]            Cmd_B_In,
    output logic                   ALU_Enable_Out,
    output logic [3:0]             ALU_Operation_Select_Out,
    output logic [31:0]            ALU_Data_A_Out,
    output logic [31:0]            ALU_Data_B_Out,
    input  logic [31:0]            ALU_Result_In,
    input  logic                   ALU_Carry_In,
    output logic                   Rsp_Valid_Out,
    input  logic                   Rsp_Ready_In,
    output logic [31:0]            Rsp_Result_Out,
    output logic                   Rsp_Carry_Out,
    output logic                   Rsp_Error_Out,
    output logic [COUNT_WIDTH-1:0] Op_Count_Out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [3:0]             op_q, op_d;
    logic [31:0]            a_q, a_d;
    logic [31:0]            b_q, b_d;
    logic [31:0]            res_q, res_d;
    logic                   carry_q, carry_d;
    logic                   err_q, err_d;
    logic [31:0]            chain_q, chain_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic        accept;
    logic        div_zero;
    logic [31:0] eff_a;

    // Ready is qualified by reset so nothing is accepted while reset is held.
    assign Cmd_Ready_Out = (state_q == IDLE) && !Reset_In;
    assign accept        = Cmd_Valid_In && Cmd_Ready_Out;
    assign eff_a         = Cmd_Chain_In ? chain_q : Cmd_A_In;
    assign div_zero      = ((Cmd_Op_In == 4'h6) || (Cmd_Op_In == 4'h7)) && (Cmd_B_In == 32'h0);

    // Enable/valid decode straight from state so an async reset drops them at once.
    assign ALU_Enable_Out           = (state_q == DRIVE);
    assign Rsp_Valid_Out            = (state_q == RESPOND);
    assign ALU_Operation_Select_Out = op_q;
    assign ALU_Data_A_Out           = a_q;
    assign ALU_Data_B_Out           = b_q;
    assign Rsp_Result_Out           = res_q;
    assign Rsp_Carry_Out            = carry_q;
    assign Rsp_Error_Out            = err_q;
    assign Op_Count_Out             = count_q;

    // Next-state and datapath update; ALU-facing registers only load for ops that use the ALU.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        err_d   = err_q;
        chain_d = chain_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (div_zero) begin
                        res_d   = 32'hFFFF_FFFF;
                        carry_d = 1'b0;
                        err_d   = 1'b1;
                        state_d = RESPOND;
                    end else begin
                        op_d    = Cmd_Op_In;
                        a_d     = eff_a;
                        b_d     = Cmd_B_In;
                        cnt_d   = 4'd0;
                        state_d = DRIVE;
                    end
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    res_d   = ALU_Result_In;
                    carry_d = ALU_Carry_In;
                    err_d   = 1'b0;
                    chain_d = ALU_Result_In;
                    state_d = RESPOND;
                end
            end
            RESPOND: begin
                if (Rsp_Ready_In) begin
                    count_d = count_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight command.
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            chain_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            chain_q <= chain_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_alu_command_initiator.sv
// Scoreboard bench: stimulus pushes expected responses, a monitor pops and compares.
module tb_alu_command_initiator;

    localparam int S  = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          Reset_In = 1'b1;
    logic          Cmd_Valid_In = 1'b0;
    logic          Cmd_Ready_Out;
    logic [3:0]    Cmd_Op_In = '0;
    logic          Cmd_Chain_In = 1'b0;
    logic [31:0]   Cmd_A_In = '0;
    logic [31:0]   Cmd_B_In = '0;
    logic          ALU_Enable_Out;
    logic [3:0]    ALU_Operation_Select_Out;
    logic [31:0]   ALU_Data_A_Out;
    logic [31:0]   ALU_Data_B_Out;
    logic [31:0]   alu_r = '0;
    logic          alu_c = 1'b0;
    logic          Rsp_Valid_Out;
    logic          Rsp_Ready_In = 1'b0;
    logic [31:0]   Rsp_Result_Out;
    logic          Rsp_Carry_Out;
    logic          Rsp_Error_Out;
    logic [CW-1:0] Op_Count_Out;

    alu_command_initiator #(.SETTLE_CYCLES(S), .COUNT_WIDTH(CW)) dut (
        .Clk_In(clk), .Reset_In(Reset_In),
        .Cmd_Valid_In(Cmd_Valid_In), .Cmd_Ready_Out(Cmd_Ready_Out),
        .Cmd_Op_In(Cmd_Op_In), .Cmd_Chain_In(Cmd_Chain_In),
        .Cmd_A_In(Cmd_A_In), .Cmd_B_In(Cmd_B_In),
        .ALU_Enable_Out(ALU_Enable_Out), .ALU_Operation_Select_Out(ALU_Operation_Select_Out),
        .ALU_Data_A_Out(ALU_Data_A_Out), .ALU_Data_B_Out(ALU_Data_B_Out),
        .ALU_Result_In(alu_r), .ALU_Carry_In(alu_c),
        .Rsp_Valid_Out(Rsp_Valid_Out), .Rsp_Ready_In(Rsp_Ready_In),
        .Rsp_Result_Out(Rsp_Result_Out), .Rsp_Carry_Out(Rsp_Carry_Out),
        .Rsp_Error_Out(Rsp_Error_Out), .Op_Count_Out(Op_Count_Out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: {carry, result}
    function automatic logic [32:0] alu_f(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        case (op)
            4'h0: return {1'b0, a} + 33'd1;
            4'h1: return {1'b0, a} - 33'd1;
            4'h2: return {1'b0, a} + {1'b0, b};
            4'h3: return {1'b0, a} - {1'b0, b};
            4'h4: return {1'b0, a & b};
            4'h5: return {1'b0, a * b};
            4'h6: return {1'b0, (b == 0) ? 32'hFFFF_FFFF : a / b};
            4'h7: return {1'b0, (b == 0) ? 32'hFFFF_FFFF : a % b};
            4'h8: return {1'b0, a | b};
            4'h9: return {1'b0, a ^ b};
            4'hA: return {1'b0, ~a};
            4'hB: return {1'b0, a << b[4:0]};
            4'hC: return {1'b0, a >> b[4:0]};
            4'hD: return {1'b0, 32'($signed(a) >>> b[4:0])};
            4'hE: return {1'b0, (a < b) ? 32'd1 : 32'd0};
            default: return {1'b0, b};
        endcase
    endfunction

    // ALU stand-in with one register of settle delay, so early sampling returns stale data.
    always @(posedge clk) if (ALU_Enable_Out) {alu_c, alu_r} <= alu_f(ALU_Operation_Select_Out, ALU_Data_A_Out, ALU_Data_B_Out);

    typedef struct {
        logic [31:0] res;
        logic        c;
        logic        e;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          rise;
    } exp_t;

    exp_t        q[$];
    int          vecs = 0;
    int          errs = 0;
    logic [31:0] chain_m = '0;
    int          mcnt = 0;
    int          rdy_force = -1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(string name);
        vecs++;
        errs++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Response-ready driver
    initial forever begin
        @(posedge clk);
        #1;
        Rsp_Ready_In = (rdy_force < 0) ? 1'($urandom % 2) : rdy_force[0];
    end

    // Monitor
    initial begin
        bit   in_rsp;
        int   en_cnt;
        exp_t e;
        in_rsp = 0;
        en_cnt = 0;
        forever begin
            @(negedge clk);
            if (Reset_In) begin
                chk("rst_ready", 32'(Cmd_Ready_Out), 0);
                chk("rst_en", 32'(ALU_Enable_Out), 0);
                chk("rst_valid", 32'(Rsp_Valid_Out), 0);
                chk("rst_count", 32'(Op_Count_Out), 0);
                chk("rst_res", Rsp_Result_Out, 0);
                chk("rst_err", 32'(Rsp_Error_Out), 0);
                chk("rst_alu_a", ALU_Data_A_Out, 0);
                q.delete();
                mcnt   = 0;
                in_rsp = 0;
                en_cnt = 0;
            end else begin
                chk("op_count", 32'(Op_Count_Out), 32'(mcnt));
                if (ALU_Enable_Out) begin
                    en_cnt++;
                    if (q.size() == 0) flag("enable_without_command");
                    else begin
                        chk("alu_op", 32'(ALU_Operation_Select_Out), 32'(q[0].op));
                        chk("alu_a", ALU_Data_A_Out, q[0].a);
                        chk("alu_b", ALU_Data_B_Out, q[0].b);
                    end
                end
                if (Rsp_Valid_Out) begin
                    if (q.size() == 0) flag("spurious_response");
                    else begin
                        e = q[0];
                        if (!in_rsp) begin
                            in_rsp = 1;
                            chk("rsp_latency", 32'(cyc), 32'(e.rise));
                            chk("enable_cycles", 32'(en_cnt), e.e ? 0 : S);
                        end
                        chk("rsp_result", Rsp_Result_Out, e.res);
                        chk("rsp_carry", 32'(Rsp_Carry_Out), 32'(e.c));
                        chk("rsp_error", 32'(Rsp_Error_Out), 32'(e.e));
                        chk("ready_in_respond", 32'(Cmd_Ready_Out), 0);
                        if (Rsp_Ready_In) begin
                            void'(q.pop_front());
                            mcnt   = (mcnt + 1) % (1 << CW);
                            in_rsp = 0;
                            en_cnt = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic ch, input logic [31:0] a,
                        input logic [31:0] b, output int waited);
        exp_t        e;
        logic [32:0] r;
        bit          got;
        got    = 0;
        waited = 0;
        @(posedge clk);
        #1;
        Cmd_Valid_In = 1'b1;
        Cmd_Op_In    = op;
        Cmd_Chain_In = ch;
        Cmd_A_In     = a;
        Cmd_B_In     = b;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            waited++;
            if (Cmd_Ready_Out === 1'b1) got = 1;
        end
        if (!got) flag("accept_timeout");
        else begin
            e.op = op;
            e.a  = ch ? chain_m : a;
            e.b  = b;
            if ((op == 4'h6 || op == 4'h7) && b == 0) begin
                e.res  = 32'hFFFF_FFFF;
                e.c    = 1'b0;
                e.e    = 1'b1;
                e.rise = cyc + 1;
            end else begin
                r       = alu_f(op, e.a, b);
                e.res   = r[31:0];
                e.c     = r[32];
                e.e     = 1'b0;
                e.rise  = cyc + 1 + S;
                chain_m = r[31:0];
            end
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        Cmd_Valid_In = 1'b0;
        Cmd_Op_In    = 4'($urandom);
        Cmd_Chain_In = 1'($urandom);
        Cmd_A_In     = $urandom;
        Cmd_B_In     = $urandom;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (Cmd_Ready_Out === 1'b1 && q.size() == 0) done = 1;
        end
        if (!done) flag("idle_timeout");
    endtask

    initial begin
        int w;
        logic [31:0] rb;
        // Reset held three cycles
        repeat (3) @(posedge clk);
        #1 Reset_In = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(Cmd_Ready_Out), 1);

        rdy_force = 1;
        // Carry out of add
        send(4'h2, 1'b0, 32'hFFFF_FFFF, 32'h1, w);
        // Divide and modulo by zero
        send(4'h6, 1'b0, 32'h1234, 32'h0, w);
        send(4'h7, 1'b0, $urandom, 32'h0, w);
        // Chaining
        send(4'h2, 1'b0, 32'd5, 32'd7, w);
        send(4'h5, 1'b1, $urandom, 32'd3, w);
        send(4'h3, 1'b1, $urandom, 32'h24, w);
        wait_idle();
        chk("chain_final", chain_m, 32'h0);

        // Backpressure with a pending command
        rdy_force = 0;
        send(4'h4, 1'b0, $urandom, $urandom, w);
        for (int i = 0; i < 20 && Rsp_Valid_Out !== 1'b1; i++) @(negedge clk);
        @(posedge clk);
        #1;
        rb = $urandom;
        Cmd_Valid_In = 1'b1; Cmd_Op_In = 4'h9; Cmd_Chain_In = 1'b0; Cmd_A_In = rb; Cmd_B_In = ~rb;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 32'(Rsp_Valid_Out), 1);
            chk("bp_ready", 32'(Cmd_Ready_Out), 0);
        end
        rdy_force = 1;
        send(4'h9, 1'b0, rb, ~rb, w);
        chk("bp_accept_delay", 32'(w), 2);
        wait_idle();

        // Reset during the second enable cycle
        send(4'h2, 1'b0, 32'd1, 32'd1, w);
        @(posedge clk);
        #2;
        chk("mid_en_before", 32'(ALU_Enable_Out), 1);
        Reset_In = 1'b1;
        #1;
        chk("mid_en_dropped", 32'(ALU_Enable_Out), 0);
        chk("mid_valid_dropped", 32'(Rsp_Valid_Out), 0);
        chain_m = '0;
        repeat (2) @(posedge clk);
        #1 Reset_In = 1'b0;
        send(4'h0, 1'b1, $urandom, $urandom, w);
        wait_idle();
        chk("chain_after_reset", chain_m, 32'h1);

        // Randomized traffic, enough completions to wrap the counter
        rdy_force = -1;
        for (int n = 0; n < 150; n++) begin
            logic [31:0] bb;
            bb = ($urandom % 4 == 0) ? 32'h0 : (($urandom % 2) ? $urandom : 32'($urandom % 64));
            send(4'($urandom), ($urandom % 3 == 0), $urandom, bb, w);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
